// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - pixel-enable input and VGA timing outputs of the sync generator
interface vga_sync_gen_if;
  logic       pix_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pix_tick,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output pix_tick,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator advanced by a pixel clock enable
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (vga.pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d      = '0;
        line_start_d = 1'b1;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    // Decode the next counts so sync/visible flags register alongside the counters they describe
    hsync_d    = (h_cnt_d >= H_SYNC_BEG && h_cnt_d <= H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = (v_cnt_d >= V_SYNC_BEG && v_cnt_d <= V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_x     = h_cnt_q;
  assign vga.pixel_y     = v_cnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench: default timing plus a shrunken frame for full-frame and polarity runs
module tb_vga_sync_gen;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
    bit pol;
  } cfg_t;

  localparam int H_TOT0 = 640 + 16 + 96 + 48;
  localparam int V_TOT0 = 480 + 10 + 2 + 33;
  if (H_TOT0 > 1024 || V_TOT0 > 1024) begin : g_tot_bad
    initial $fatal(1, "FAIL totals: H %0d V %0d exceed 1024", H_TOT0, V_TOT0);
  end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  vga_sync_gen_if if0();
  vga_sync_gen_if if1();
  vga_sync_gen_if if2();

  vga_sync_gen u_dut0 (.clk(clk), .reset(rst0), .vga(if0.master));
  vga_sync_gen #(.H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                 .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4))
    u_dut1 (.clk(clk), .reset(rst1), .vga(if1.master));
  vga_sync_gen #(.H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                 .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .SYNC_POL(1'b1))
    u_dut2 (.clk(clk), .reset(rst2), .vga(if2.master));

  out_t obs0, obs1, obs2;
  assign obs0 = {if0.pixel_x, if0.pixel_y, if0.hsync, if0.vsync, if0.video_on, if0.line_start, if0.frame_start};
  assign obs1 = {if1.pixel_x, if1.pixel_y, if1.hsync, if1.vsync, if1.video_on, if1.line_start, if1.frame_start};
  assign obs2 = {if2.pixel_x, if2.pixel_y, if2.hsync, if2.vsync, if2.video_on, if2.line_start, if2.frame_start};

  cfg_t cfg [3];
  int   mx [3];
  int   my [3];
  out_t q0[$], q1[$], q2[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string fmt(input out_t o);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b", o.x, o.y, o.hs, o.vs, o.von, o.ls, o.fs);
  endfunction

  // Reference timing model, advanced once per driven cycle
  function automatic out_t model_step(input int d, input bit t, input bit r);
    cfg_t c;
    int ht, vt, hsb, vsb;
    out_t o;
    c   = cfg[d];
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    hsb = c.hv + c.hf;
    vsb = c.vv + c.vf;
    o.ls = 1'b0;
    o.fs = 1'b0;
    if (r) begin
      mx[d] = ht - 1;
      my[d] = vt - 1;
    end else if (t) begin
      if (mx[d] == ht - 1) begin
        mx[d] = 0;
        o.ls  = 1'b1;
        if (my[d] == vt - 1) begin
          my[d] = 0;
          o.fs  = 1'b1;
        end else begin
          my[d] = my[d] + 1;
        end
      end else begin
        mx[d] = mx[d] + 1;
      end
    end
    o.x   = 10'(mx[d]);
    o.y   = 10'(my[d]);
    o.hs  = (mx[d] >= hsb && mx[d] < hsb + c.hs) ? c.pol : ~c.pol;
    o.vs  = (my[d] >= vsb && my[d] < vsb + c.vs) ? c.pol : ~c.pol;
    o.von = (mx[d] < c.hv) && (my[d] < c.vv);
    return o;
  endfunction

  task automatic step0(input bit t, input bit r);
    @(negedge clk);
    if0.pix_tick = t;
    rst0 = r;
    q0.push_back(model_step(0, t, r));
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input bit t, input bit r);
    @(negedge clk);
    if1.pix_tick = t;
    rst1 = r;
    q1.push_back(model_step(1, t, r));
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input bit r);
    @(negedge clk);
    rst2 = r;
    q2.push_back(model_step(2, 1'b1, r));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, rexp;
    rexp = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step0(1'b0, 1'b1);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL reset_hold: got %s want %s", fmt(obs0), fmt(e)); end
    end
    checks++;
    if (obs0 !== rexp) begin errors++; $display("FAIL reset_values: got %s want %s", fmt(obs0), fmt(rexp)); end
    for (int i = 0; i < 10; i++) begin
      step0(1'b0, 1'b0);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL idle_hold: got %s want %s", fmt(obs0), fmt(e)); end
    end
  endtask

  task automatic test_first_tick();
    out_t e, fexp;
    fexp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    step0(1'b1, 1'b0);
    e = q0.pop_front();
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL first_tick: got %s want %s", fmt(obs0), fmt(e)); end
    checks++;
    if (obs0 !== fexp) begin errors++; $display("FAIL first_tick_abs: got %s want %s", fmt(obs0), fmt(fexp)); end
    step0(1'b0, 1'b0);
    e = q0.pop_front();
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL strobe_clear: got %s want %s", fmt(obs0), fmt(e)); end
  endtask

  task automatic test_line();
    out_t e;
    logic prev_hs, prev_von;
    int hs_fall, hs_rise, von_fall, ls_cnt;
    prev_hs = obs0.hs; prev_von = obs0.von;
    hs_fall = -1; hs_rise = -1; von_fall = -1; ls_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      for (int k = 0; k < 2; k++) begin
        step0(k == 0, 1'b0);
        e = q0.pop_front();
        checks++;
        if (obs0 !== e) begin errors++; $display("FAIL line_scan: got %s want %s", fmt(obs0), fmt(e)); end
        if (obs0.ls) ls_cnt++;
        if (prev_hs && !obs0.hs && hs_fall < 0) hs_fall = int'(obs0.x);
        if (!prev_hs && obs0.hs && hs_rise < 0) hs_rise = int'(obs0.x);
        if (prev_von && !obs0.von && von_fall < 0) von_fall = int'(obs0.x);
        prev_hs = obs0.hs; prev_von = obs0.von;
      end
    end
    checks++;
    if (hs_fall != 656) begin errors++; $display("FAIL hsync_fall_x: got %0d want 656", hs_fall); end
    checks++;
    if (hs_rise != 752) begin errors++; $display("FAIL hsync_rise_x: got %0d want 752", hs_rise); end
    checks++;
    if (von_fall != 640) begin errors++; $display("FAIL video_off_x: got %0d want 640", von_fall); end
    checks++;
    if (ls_cnt != 2) begin errors++; $display("FAIL line_start_count: got %0d want 2", ls_cnt); end
    checks++;
    if (obs0.y !== 10'd2) begin errors++; $display("FAIL line_advance_y: got %0d want 2", obs0.y); end
  endtask

  task automatic test_frame();
    out_t e;
    bit t;
    int ticks, fs_seen, vs_min, vs_max, von_bad, cyc;
    for (int i = 0; i < 2; i++) begin
      step1(1'b0, 1'b1);
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL frame_reset: got %s want %s", fmt(obs1), fmt(e)); end
    end
    ticks = 0; fs_seen = 0; vs_min = 1000; vs_max = -1; von_bad = 0; cyc = 0;
    while (fs_seen < 3 && cyc < 6000) begin
      t = 1'($urandom_range(0, 1));
      step1(t, 1'b0);
      cyc++;
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL frame_scan: got %s want %s", fmt(obs1), fmt(e)); end
      if (t) ticks++;
      if (!obs1.vs) begin
        if (int'(obs1.y) < vs_min) vs_min = int'(obs1.y);
        if (int'(obs1.y) > vs_max) vs_max = int'(obs1.y);
      end
      if (obs1.von && obs1.y >= 10'd12) von_bad++;
      if (obs1.fs) begin
        if (fs_seen > 0) begin
          checks++;
          if (ticks != 640) begin errors++; $display("FAIL frame_period: got %0d ticks want 640", ticks); end
        end
        fs_seen++;
        ticks = 0;
      end
    end
    checks++;
    if (fs_seen < 3) begin errors++; $display("FAIL frame_timeout: got %0d frame_starts want 3", fs_seen); end
    checks++;
    if (vs_min != 14 || vs_max != 15) begin errors++; $display("FAIL vsync_lines: got %0d..%0d want 14..15", vs_min, vs_max); end
    checks++;
    if (von_bad != 0) begin errors++; $display("FAIL video_on_blank: got %0d want 0", von_bad); end
  endtask

  task automatic test_midframe_reset();
    out_t e, rexp, fexp;
    int cyc;
    rexp = {10'd31, 10'd19, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fexp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    cyc = 0;
    while (!(obs1.x == 10'd20 && obs1.y == 10'd10) && cyc < 1000) begin
      step1(1'b1, 1'b0);
      cyc++;
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL seek_scan: got %s want %s", fmt(obs1), fmt(e)); end
    end
    checks++;
    if (cyc >= 1000) begin errors++; $display("FAIL seek_timeout: got %s want x=20 y=10", fmt(obs1)); end
    step1(1'b1, 1'b1);
    e = q1.pop_front();
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL midframe_reset: got %s want %s", fmt(obs1), fmt(e)); end
    checks++;
    if (obs1 !== rexp) begin errors++; $display("FAIL midframe_reset_abs: got %s want %s", fmt(obs1), fmt(rexp)); end
    step1(1'b1, 1'b0);
    e = q1.pop_front();
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL restart_tick: got %s want %s", fmt(obs1), fmt(e)); end
    checks++;
    if (obs1 !== fexp) begin errors++; $display("FAIL restart_tick_abs: got %s want %s", fmt(obs1), fmt(fexp)); end
  endtask

  task automatic test_sync_pol();
    out_t e;
    int clks, fs_seen, hs_min, hs_max, vs_min, vs_max;
    for (int i = 0; i < 2; i++) begin
      step2(1'b1);
      e = q2.pop_front();
      checks++;
      if (obs2 !== e) begin errors++; $display("FAIL pol_reset: got %s want %s", fmt(obs2), fmt(e)); end
    end
    checks++;
    if (obs2.hs !== 1'b0 || obs2.vs !== 1'b0) begin
      errors++; $display("FAIL pol_idle: got hs=%b vs=%b want 0 0", obs2.hs, obs2.vs);
    end
    clks = 0; fs_seen = 0; hs_min = 1000; hs_max = -1; vs_min = 1000; vs_max = -1;
    for (int i = 0; i < 1400; i++) begin
      step2(1'b0);
      e = q2.pop_front();
      checks++;
      if (obs2 !== e) begin errors++; $display("FAIL pol_scan: got %s want %s", fmt(obs2), fmt(e)); end
      clks++;
      if (obs2.hs) begin
        if (int'(obs2.x) < hs_min) hs_min = int'(obs2.x);
        if (int'(obs2.x) > hs_max) hs_max = int'(obs2.x);
      end
      if (obs2.vs) begin
        if (int'(obs2.y) < vs_min) vs_min = int'(obs2.y);
        if (int'(obs2.y) > vs_max) vs_max = int'(obs2.y);
      end
      if (obs2.fs) begin
        if (fs_seen > 0) begin
          checks++;
          if (clks != 640) begin errors++; $display("FAIL pol_frame_period: got %0d clk want 640", clks); end
        end
        fs_seen++;
        clks = 0;
      end
    end
    checks++;
    if (fs_seen != 3) begin errors++; $display("FAIL pol_frame_count: got %0d want 3", fs_seen); end
    checks++;
    if (hs_min != 20 || hs_max != 27) begin errors++; $display("FAIL pol_hsync_span: got %0d..%0d want 20..27", hs_min, hs_max); end
    checks++;
    if (vs_min != 14 || vs_max != 15) begin errors++; $display("FAIL pol_vsync_span: got %0d..%0d want 14..15", vs_min, vs_max); end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cfg[1] = '{16, 4, 8, 4, 12, 2, 2, 4, 1'b0};
    cfg[2] = '{16, 4, 8, 4, 12, 2, 2, 4, 1'b1};
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.pix_tick = 1'b0;
    if1.pix_tick = 1'b0;
    if2.pix_tick = 1'b1;
    test_reset();
    test_first_tick();
    test_line();
    test_frame();
    test_midframe_reset();
    test_sync_pol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
